pacman_move_ctrl: RTL and testbench

- Owns the player sprite position on the maze block grid and advances it one sub-step per move tick.
- Drives block_x_reg/block_y_reg into walk_detect and consumes the 4-bit legal-direction mask it returns, in the same cycle.
- Buffers a one-hot direction request and applies it at the next legal block centre; stops against walls.
- Reverses immediately mid-step.
- Outputs block coordinates for pellet/collision logic and pixel coordinates for the VGA sprite renderer.

---
 rtl/pacman_move_ctrl.sv | 148 ++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pacman_move_ctrl.sv
// Player sprite movement controller for the maze grid.
// Tracks the departing block, the sub-step offset from its centre, the
// direction of motion and one buffered direction request. The pixel position
// is registered together with the block/offset state so the renderer and the
// pellet/collision logic always see one consistent position.
module pacman_move_ctrl #(
  parameter int STEPS    = 4,
  parameter int BLOCK_PX = 16,
  parameter int START_X  = 20,
  parameter int START_Y  = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       dir_req_valid,
  input  logic [3:0] dir_req,
  input  logic [3:0] valid,
  output logic [9:0] block_x_reg,
  output logic [9:0] block_y_reg,
  output logic [3:0] sub_off,
  output logic [3:0] cur_dir,
  output logic [3:0] pend_dir,
  output logic       block_arrive,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam logic [3:0] STEPS_L  = 4'(STEPS);
  localparam logic [9:0] BPX      = 10'(BLOCK_PX);
  localparam logic [9:0] PXS      = 10'(BLOCK_PX / STEPS);
  localparam logic [9:0] RST_BX   = 10'(START_X);
  localparam logic [9:0] RST_BY   = 10'(START_Y);
  localparam logic [9:0] RST_PX   = 10'(START_X * BLOCK_PX);
  localparam logic [9:0] RST_PY   = 10'(START_Y * BLOCK_PX);

  // Direction bits: [3] down (y+1), [2] up (y-1), [1] right (x+1), [0] left (x-1).

  logic [9:0] r_bx, r_by, r_px, r_py;
  logic [3:0] r_sub, r_cur, r_pend;
  logic       r_arrive;

  logic [9:0] w_bx, w_by, w_adv_x, w_adv_y;
  logic [3:0] w_sub, w_cur, w_pend, w_eff, w_opp;
  logic       w_arrive, w_req_ok, w_in_step, w_rev;

  // One block step along a direction axis; walk_detect never allows an edge
  // exit, so no wrap handling is needed.
  function automatic logic [9:0] f_adv(input logic [9:0] pos, input logic inc,
                                       input logic dec);
    if (inc)      return pos + 10'd1;
    else if (dec) return pos - 10'd1;
    else          return pos;
  endfunction

  // Sprite pixel coordinate on one axis: block origin offset by the sub-steps
  // already walked toward the neighbouring block.
  function automatic logic [9:0] f_pix(input logic [9:0] blk, input logic [3:0] sub,
                                       input logic plus, input logic minus);
    logic [9:0] base, off;
    base = blk * BPX;
    off  = {6'd0, sub} * PXS;
    if (plus)       return base + off;
    else if (minus) return base - off;
    else            return base;
  endfunction

  assign w_req_ok  = dir_req_valid && (dir_req != 4'd0) &&
                     ((dir_req & (dir_req - 4'd1)) == 4'd0);
  assign w_eff     = w_req_ok ? dir_req : r_pend;
  assign w_opp     = {r_cur[2], r_cur[3], r_cur[0], r_cur[1]};
  assign w_in_step = (r_sub != 4'd0);
  assign w_rev     = w_in_step && w_req_ok && (dir_req == w_opp);
  assign w_adv_x   = f_adv(r_bx, r_cur[1], r_cur[0]);
  assign w_adv_y   = f_adv(r_by, r_cur[3], r_cur[2]);

  // Next-state decision: reversal beats the tick; otherwise a tick either
  // starts/continues/stops motion at a centre or advances within a step.
  always_comb begin
    w_bx     = r_bx;
    w_by     = r_by;
    w_sub    = r_sub;
    w_cur    = r_cur;
    w_pend   = w_req_ok ? dir_req : r_pend;
    w_arrive = 1'b0;
    if (w_rev) begin
      // The target block becomes the departing block, so the pixel stays put.
      w_bx     = w_adv_x;
      w_by     = w_adv_y;
      w_sub    = STEPS_L - r_sub;
      w_cur    = w_opp;
      w_pend   = 4'd0;
      w_arrive = 1'b1;
    end else if (move_tick) begin
      if (!w_in_step) begin
        if ((w_eff & valid) != 4'd0) begin
          w_cur  = w_eff;
          w_pend = 4'd0;
          w_sub  = 4'd1;
        end else if ((r_cur & valid) != 4'd0) begin
          w_sub = 4'd1;
        end else begin
          w_cur = 4'd0;
          w_sub = 4'd0;
        end
      end else if (r_sub < STEPS_L - 4'd1) begin
        w_sub = r_sub + 4'd1;
      end else begin
        w_sub    = 4'd0;
        w_bx     = w_adv_x;
        w_by     = w_adv_y;
        w_arrive = 1'b1;
      end
    end
  end

  // State and pixel registers, all reset synchronously to the start block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bx     <= RST_BX;
      r_by     <= RST_BY;
      r_sub    <= 4'd0;
      r_cur    <= 4'd0;
      r_pend   <= 4'd0;
      r_arrive <= 1'b0;
      r_px     <= RST_PX;
      r_py     <= RST_PY;
    end else begin
      r_bx     <= w_bx;
      r_by     <= w_by;
      r_sub    <= w_sub;
      r_cur    <= w_cur;
      r_pend   <= w_pend;
      r_arrive <= w_arrive;
      r_px     <= f_pix(w_bx, w_sub, w_cur[1], w_cur[0]);
      r_py     <= f_pix(w_by, w_sub, w_cur[3], w_cur[2]);
    end
  end

  assign block_x_reg  = r_bx;
  assign block_y_reg  = r_by;
  assign sub_off      = r_sub;
  assign cur_dir      = r_cur;
  assign pend_dir     = r_pend;
  assign block_arrive = r_arrive;
  assign pixel_x      = r_px;
  assign pixel_y      = r_py;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with default parameters
// (STEPS=4, BLOCK_PX=16, start block 20,21 -> pixel 320,336).
module tb_pacman_move_ctrl;

  logic       clk = 1'b0;
  logic       rst, move_tick, dir_req_valid;
  logic [3:0] dir_req, valid;
  logic [9:0] block_x_reg, block_y_reg, pixel_x, pixel_y;
  logic [3:0] sub_off, cur_dir, pend_dir;
  logic       block_arrive;

  int n_tests = 0;
  int n_fail  = 0;

  pacman_move_ctrl dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .dir_req_valid(dir_req_valid),
    .dir_req(dir_req), .valid(valid), .block_x_reg(block_x_reg),
    .block_y_reg(block_y_reg), .sub_off(sub_off), .cur_dir(cur_dir),
    .pend_dir(pend_dir), .block_arrive(block_arrive), .pixel_x(pixel_x),
    .pixel_y(pixel_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given tick/request inputs; outputs settle 1 time unit later.
  task automatic cyc(input logic t, input logic rv, input logic [3:0] rq);
    move_tick = t; dir_req_valid = rv; dir_req = rq;
    @(posedge clk); #1;
    move_tick = 1'b0; dir_req_valid = 1'b0; dir_req = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bx"}, int'(block_x_reg), 20);
    chk({tag, "_by"}, int'(block_y_reg), 21);
    chk({tag, "_sub"}, int'(sub_off), 0);
    chk({tag, "_cur"}, int'(cur_dir), 0);
    chk({tag, "_pend"}, int'(pend_dir), 0);
    chk({tag, "_arr"}, int'(block_arrive), 0);
    chk({tag, "_px"}, int'(pixel_x), 320);
    chk({tag, "_py"}, int'(pixel_y), 336);
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; dir_req_valid = 1'b0; dir_req = 4'd0; valid = 4'd0;
    @(negedge clk);
    do_reset();
    chk_reset("rst");

    // Left run from start with a turn request buffered mid-step
    valid = 4'b0011;
    cyc(1'b0, 1'b1, 4'b0001);
    chk("left_pend", int'(pend_dir), 1);
    chk("left_still", int'(sub_off), 0);
    cyc(1'b1, 1'b0, 4'd0);
    chk("left_t1_sub", int'(sub_off), 1);
    chk("left_t1_cur", int'(cur_dir), 1);
    chk("left_t1_pend", int'(pend_dir), 0);
    chk("left_t1_px", int'(pixel_x), 316);
    cyc(1'b1, 1'b0, 4'd0);
    chk("left_t2_sub", int'(sub_off), 2);
    chk("left_t2_px", int'(pixel_x), 312);
    cyc(1'b0, 1'b1, 4'b0100);
    chk("buf_pend", int'(pend_dir), 4);
    chk("buf_cur", int'(cur_dir), 1);
    chk("buf_sub", int'(sub_off), 2);
    cyc(1'b1, 1'b0, 4'd0);
    chk("left_t3_sub", int'(sub_off), 3);
    chk("left_t3_px", int'(pixel_x), 308);
    chk("left_t3_arr", int'(block_arrive), 0);
    cyc(1'b1, 1'b0, 4'd0);
    chk("left_t4_sub", int'(sub_off), 0);
    chk("left_t4_bx", int'(block_x_reg), 19);
    chk("left_t4_arr", int'(block_arrive), 1);
    chk("left_t4_px", int'(pixel_x), 304);
    cyc(1'b0, 1'b0, 4'd0);
    chk("arr_pulse", int'(block_arrive), 0);
    chk("idle_sub", int'(sub_off), 0);

    // Buffered turn applied at the centre of (19,21)
    valid = 4'b0111;
    cyc(1'b1, 1'b0, 4'd0);
    chk("turn_cur", int'(cur_dir), 4);
    chk("turn_pend", int'(pend_dir), 0);
    chk("turn_sub", int'(sub_off), 1);
    chk("turn_py", int'(pixel_y), 332);
    chk("turn_px", int'(pixel_x), 304);

    // Reversal without tick, then reversal together with a tick (tick dropped)
    cyc(1'b0, 1'b1, 4'b1000);
    chk("rev1_by", int'(block_y_reg), 20);
    chk("rev1_sub", int'(sub_off), 3);
    chk("rev1_cur", int'(cur_dir), 8);
    chk("rev1_arr", int'(block_arrive), 1);
    chk("rev1_py", int'(pixel_y), 332);
    cyc(1'b1, 1'b1, 4'b0100);
    chk("rev2_by", int'(block_y_reg), 21);
    chk("rev2_sub", int'(sub_off), 1);
    chk("rev2_cur", int'(cur_dir), 4);
    chk("rev2_py", int'(pixel_y), 332);

    // Illegal requests, overwrite, same-cycle request with tick, right reversal
    do_reset();
    valid = 4'b0010;
    cyc(1'b0, 1'b1, 4'b0011);
    chk("ill_pend0", int'(pend_dir), 0);
    cyc(1'b0, 1'b1, 4'b0100);
    chk("ill_pend_up", int'(pend_dir), 4);
    cyc(1'b0, 1'b1, 4'b0011);
    chk("ill_keep", int'(pend_dir), 4);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("ill_zero", int'(pend_dir), 4);
    cyc(1'b1, 1'b1, 4'b0010);
    chk("same_cur", int'(cur_dir), 2);
    chk("same_sub", int'(sub_off), 1);
    chk("same_pend", int'(pend_dir), 0);
    chk("same_px", int'(pixel_x), 324);
    cyc(1'b0, 1'b1, 4'b0001);
    chk("revr_bx", int'(block_x_reg), 21);
    chk("revr_sub", int'(sub_off), 3);
    chk("revr_cur", int'(cur_dir), 1);
    chk("revr_px", int'(pixel_x), 324);
    chk("revr_arr", int'(block_arrive), 1);

    // Reset mid-step while moving up, with a tick during reset
    do_reset();
    valid = 4'b0100;
    cyc(1'b1, 1'b1, 4'b0100);
    cyc(1'b1, 1'b0, 4'd0);
    chk("mid_sub", int'(sub_off), 2);
    chk("mid_py", int'(pixel_y), 328);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 4'b0001);
    rst = 1'b0;
    chk_reset("midrst");

    // Travel to (2,2) heading left, then hit a wall and restart downward
    valid = 4'b0100;
    cyc(1'b1, 1'b1, 4'b0100);
    for (int i = 1; i < 19 * 4; i++) cyc(1'b1, 1'b0, 4'd0);
    chk("trav_by", int'(block_y_reg), 2);
    valid = 4'b0001;
    cyc(1'b1, 1'b1, 4'b0001);
    for (int i = 1; i < 18 * 4; i++) cyc(1'b1, 1'b0, 4'd0);
    chk("trav_bx", int'(block_x_reg), 2);
    chk("trav_cur", int'(cur_dir), 1);
    chk("trav_sub", int'(sub_off), 0);
    chk("trav_px", int'(pixel_x), 32);
    chk("trav_py", int'(pixel_y), 32);
    valid = 4'b1010;
    cyc(1'b1, 1'b0, 4'd0);
    chk("wall_cur", int'(cur_dir), 0);
    chk("wall_sub", int'(sub_off), 0);
    chk("wall_bx", int'(block_x_reg), 2);
    chk("wall_px", int'(pixel_x), 32);
    cyc(1'b0, 1'b1, 4'b1000);
    chk("wall_pend", int'(pend_dir), 8);
    cyc(1'b1, 1'b0, 4'd0);
    chk("down_cur", int'(cur_dir), 8);
    chk("down_sub", int'(sub_off), 1);
    chk("down_py", int'(pixel_y), 36);
    chk("down_pend", int'(pend_dir), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
